// File: rtl/ps2_keycode_if.sv
// PS/2 pin pair in, game-side keycode bus out, plus the frame FSM state for observation.
// key_valid and frame_err are single-cycle strobes with no ready/backpressure: a consumer
// must sample them in the cycle they are high; keycode is level data and stays valid between strobes.
interface ps2_keycode_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       frame_err;
  logic [1:0] fsm_state;

  modport master (
    output ps2_clk, ps2_data,
    input  keycode, key_valid, frame_err, fsm_state
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output keycode, key_valid, frame_err, fsm_state
  );
endinterface

// File: rtl/ps2_keycode_decoder.sv
// PS/2 keyboard receiver: 11-bit frame deserializer with parity/timeout checks, E0/F0
// prefix tracking and a WASD/arrow map onto HID codes held while the key is down.
module ps2_keycode_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          Clk,
  input  logic          Reset,
  ps2_keycode_if.slave  bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t     state, state_nx;
  logic       clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic       fall;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       par_bit;
  logic [15:0] to_cnt;
  logic       timeout, shift_en, par_en, err_set, byte_set, frame_ok;
  logic       byte_valid_q, frame_err_q;
  logic [7:0] byte_q;
  logic       ext, brk;
  logic [7:0] keycode_q;
  logic       key_valid_q;
  logic [7:0] mapped;

  function automatic logic [7:0] map_code(input logic is_ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    if (is_ext) begin
      case (code)
        8'h6B: m = 8'h04;
        8'h74: m = 8'h07;
        8'h72: m = 8'h16;
        8'h75: m = 8'h1A;
        default: m = 8'h00;
      endcase
    end else begin
      case (code)
        8'h1C: m = 8'h04;
        8'h23: m = 8'h07;
        8'h1B: m = 8'h16;
        8'h1D: m = 8'h1A;
        default: m = 8'h00;
      endcase
    end
    return m;
  endfunction

  // Synchronizers idle high so that reset never manufactures a falling edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= bus.ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= bus.ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall     = clk_prev & ~clk_s2;
  assign timeout  = (state != IDLE) && (to_cnt == TO_LIMIT);
  assign frame_ok = data_s2 & (^{shreg, par_bit});

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (timeout) begin
      state_nx = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_s2) state_nx = DATA;
        DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
        PARITY:  state_nx = STOP;
        STOP:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    shift_en = fall && !timeout && (state == DATA);
    par_en   = fall && !timeout && (state == PARITY);
    byte_set = fall && !timeout && (state == STOP) && frame_ok;
    err_set  = timeout
             || (fall && (state == IDLE) && data_s2)
             || (fall && (state == STOP) && !frame_ok);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      shreg        <= 8'h00;
      bit_cnt      <= 3'd0;
      par_bit      <= 1'b0;
      to_cnt       <= 16'd0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      frame_err_q  <= 1'b0;
    end else begin
      if (state == IDLE)  bit_cnt <= 3'd0;
      else if (shift_en)  bit_cnt <= bit_cnt + 3'd1;
      if (shift_en)       shreg   <= {data_s2, shreg[7:1]};
      if (par_en)         par_bit <= data_s2;
      if (state == IDLE || timeout || fall) to_cnt <= 16'd0;
      else                                  to_cnt <= to_cnt + 16'd1;
      byte_valid_q <= byte_set;
      if (byte_set) byte_q <= shreg;
      frame_err_q  <= err_set;
    end
  end

  assign mapped = map_code(ext, byte_q);

  // Prefix flags and the held key; key_valid fires only on a real value change.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ext         <= 1'b0;
      brk         <= 1'b0;
      keycode_q   <= 8'h00;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (frame_err_q) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (byte_valid_q) begin
        if (byte_q == 8'hE0) begin
          ext <= 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (mapped != 8'h00) begin
            if (brk) begin
              if (mapped == keycode_q) begin
                keycode_q   <= 8'h00;
                key_valid_q <= 1'b1;
              end
            end else if (mapped != keycode_q) begin
              keycode_q   <= mapped;
              key_valid_q <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.keycode   = keycode_q;
  assign bus.key_valid = key_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.fsm_state = state;

endmodule
